hu_mmu_bus: RTL and testbench

//  HuC6280 MMU + external bus sequencer; sits between CPU core and the memory/IO model.

---
 rtl/hu_bus_pkg.sv | 37 +++
 rtl/hu_addr_decode.sv | 30 +++
 rtl/hu_mmu_bus.sv | 172 +++++++++++++++++
 tb/tb_hu_mmu_bus.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hu_bus_pkg.sv
// Shared types and constants for the HuC6280 MMU / bus sequencer.
// Holds the physical region map, the region and bus-state enums, and a small helper.
package hu_bus_pkg;

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_NONE,
        REG_VDC,
        REG_VCE,
        REG_PSG,
        REG_TIMER,
        REG_IO
    } region_t;

    // Lower bound of each physical region; ROM occupies everything below RAM_BASE
    localparam logic [20:0] RAM_BASE   = 21'h1F0000;
    localparam logic [20:0] NONE_BASE  = 21'h1F8000;
    localparam logic [20:0] VDC_BASE   = 21'h1FE000;
    localparam logic [20:0] VCE_BASE   = 21'h1FE400;
    localparam logic [20:0] PSG_BASE   = 21'h1FE800;
    localparam logic [20:0] TIMER_BASE = 21'h1FEC00;
    localparam logic [20:0] IO_BASE    = 21'h1FF000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } bus_state_t;

    // Regions whose read data comes back from the memory model
    function automatic logic is_mem_region(input region_t r);
        return (r == REG_ROM) || (r == REG_RAM);
    endfunction

endpackage

// File: rtl/hu_addr_decode.sv
// Combinational physical-address decoder: 21-bit physical address -> region_t.
import hu_bus_pkg::*;

module hu_addr_decode (
    input  logic [20:0] pa,
    output region_t     region
);

    // Ordered range compare against the ascending region bases
    always_comb begin
        region = REG_IO;
        if (pa < RAM_BASE)
            region = REG_ROM;
        else if (pa < NONE_BASE)
            region = REG_RAM;
        else if (pa < VDC_BASE)
            region = REG_NONE;
        else if (pa < VCE_BASE)
            region = REG_VDC;
        else if (pa < PSG_BASE)
            region = REG_VCE;
        else if (pa < TIMER_BASE)
            region = REG_PSG;
        else if (pa < IO_BASE)
            region = REG_TIMER;
        else
            region = REG_IO;
    end

endmodule

// File: rtl/hu_mmu_bus.sv
// HuC6280 MMU + external bus sequencer.
// Translates CPU logical addresses through eight MPR banks, decodes the physical
// region, and runs each request as a fixed-latency bus cycle.
// Build option: define MMU_IO_WAIT_EN to add IO_WAIT wait cycles on VDC/VCE
// accesses made in high-speed mode.
import hu_bus_pkg::*;

module hu_mmu_bus #(
    parameter int          IO_WAIT  = 1,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_rdy,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    input  logic        mpr_we,
    input  logic [7:0]  mpr_sel,
    input  logic [7:0]  mpr_wdata,
    input  logic [2:0]  mpr_rsel,
    output logic [7:0]  mpr_rdata,
    input  logic        speed_hi,
    output logic [20:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    output logic        mem_re,
    output logic        mem_we,
    output logic        ce_n,
    output logic        cer_n,
    output logic        ce7_n,
    output logic        cek_n
);

    logic [7:0]  mpr [8];
    bus_state_t  state, state_nx;
    region_t     region_d, region_q;
    logic        we_q;
    logic [7:0]  rdata_q;
    logic [20:0] pa;
    logic        accept;
    logic        sel_act;
    logic        wait_go;

    // Translation uses the MPR contents before any TAM landing on the same edge
    assign pa     = {mpr[cpu_addr[15:13]], cpu_addr[12:0]};
    assign accept = (state == ST_IDLE) && cpu_req;

    hu_addr_decode u_dec (
        .pa     (pa),
        .region (region_d)
    );

    assign mpr_rdata = mpr[mpr_rsel];

    // MPR bank registers; TAM writes every bank selected in the mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 7; i++) mpr[i] <= 8'hFF;
            mpr[7] <= 8'h00;
        end else if (mpr_we) begin
            for (int i = 0; i < 8; i++)
                if (mpr_sel[i]) mpr[i] <= mpr_wdata;
        end
    end

    // Latch the translated request when it is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr <= '0;
            mem_dout <= '0;
            we_q     <= 1'b0;
            region_q <= REG_NONE;
        end else if (accept) begin
            mem_addr <= pa;
            mem_dout <= cpu_wdata;
            we_q     <= cpu_we;
            region_q <= region_d;
        end
    end

`ifdef MMU_IO_WAIT_EN
    logic       wait_req_q;
    logic [7:0] wait_cnt;

    // Wait decision is frozen at accept; the counter runs only inside WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_req_q <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            if (accept)
                wait_req_q <= speed_hi && ((region_d == REG_VDC) || (region_d == REG_VCE));
            if (state == ST_WAIT)
                wait_cnt <= wait_cnt + 8'd1;
            else
                wait_cnt <= '0;
        end
    end

    assign wait_go = wait_req_q && (IO_WAIT > 0);

    logic wait_done;
    assign wait_done = (wait_cnt >= 8'(IO_WAIT - 1));
`else
    logic unused_cfg;
    assign unused_cfg = speed_hi ^ (IO_WAIT != 0);
    assign wait_go    = 1'b0;

    logic wait_done;
    assign wait_done = 1'b1;
`endif

    // Bus state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and bus strobes
    always_comb begin
        state_nx = state;
        cpu_rdy  = 1'b0;
        cpu_ack  = 1'b0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        sel_act  = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_rdy = 1'b1;
                if (cpu_req) state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_re   = ~we_q;
                mem_we   = we_q;
                sel_act  = 1'b1;
                state_nx = wait_go ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
                sel_act = 1'b1;
                if (wait_done) state_nx = ST_RESP;
            end
            ST_RESP: begin
                cpu_ack  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Response data: memory byte for ROM/RAM reads, open bus otherwise, writes keep last value
    always_comb begin
        cpu_rdata = rdata_q;
        if (state == ST_RESP && !we_q)
            cpu_rdata = is_mem_region(region_q) ? mem_din : OPEN_BUS;
    end

    // Hold the last returned byte so writes can echo it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    rdata_q <= '0;
        else if (state == ST_RESP)  rdata_q <= cpu_rdata;
    end

    assign ce_n  = ~(sel_act && (region_q == REG_ROM));
    assign cer_n = ~(sel_act && (region_q == REG_RAM));
    assign ce7_n = ~(sel_act && (region_q == REG_VDC));
    assign cek_n = ~(sel_act && (region_q == REG_VCE));

endmodule

// File: tb/tb_hu_mmu_bus.sv
// Directed self-checking bench for hu_mmu_bus with a registered-read memory model.
module tb_hu_mmu_bus;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_rdy, cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        mpr_we = 1'b0;
    logic [7:0]  mpr_sel = '0;
    logic [7:0]  mpr_wdata = '0;
    logic [2:0]  mpr_rsel = '0;
    logic [7:0]  mpr_rdata;
    logic        speed_hi = 1'b0;
    logic [20:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = '0;
    logic        mem_re, mem_we;
    logic        ce_n, cer_n, ce7_n, cek_n;

    int n_checks = 0;
    int n_errors = 0;

    hu_mmu_bus dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdy(cpu_rdy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mpr_we(mpr_we), .mpr_sel(mpr_sel), .mpr_wdata(mpr_wdata),
        .mpr_rsel(mpr_rsel), .mpr_rdata(mpr_rdata),
        .speed_hi(speed_hi),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_re(mem_re), .mem_we(mem_we),
        .ce_n(ce_n), .cer_n(cer_n), .ce7_n(ce7_n), .cek_n(cek_n)
    );

    always #5 clk = ~clk;

    // Memory model: written bytes override a fixed address pattern; registered read port
    logic [7:0] store [int];
    always @(posedge clk) begin
        if (mem_we) store[int'(mem_addr)] = mem_dout;
        if (mem_re)
            mem_din <= store.exists(int'(mem_addr)) ? store[int'(mem_addr)]
                                                     : (mem_addr[7:0] ^ mem_addr[15:8] ^ 8'h3C);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One CPU transaction; optionally issues a TAM in the same cycle as the request.
    // Reports the strobes/selects seen in the first cycle after accept and the edges to ack.
    task automatic access(input logic we, input logic [15:0] a, input logic [7:0] d,
                          input logic tam, input logic [7:0] tsel, input logic [7:0] tdat,
                          output logic [7:0] rd, output int lat,
                          output logic [20:0] acc_addr, output logic [3:0] acc_sel,
                          output logic acc_re, output logic acc_we);
        logic got;
        got = 1'b0; rd = '0; lat = 0;
        acc_addr = '0; acc_sel = '0; acc_re = 1'b0; acc_we = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10 && !cpu_rdy; k++) @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        mpr_we = tam; mpr_sel = tsel; mpr_wdata = tdat;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            mpr_we = 1'b0;
            lat++;
            if (i == 0) begin
                acc_addr = mem_addr;
                acc_sel  = {ce_n, cer_n, ce7_n, cek_n};
                acc_re   = mem_re;
                acc_we   = mem_we;
            end
            if (cpu_ack) begin
                got = 1'b1;
                rd  = cpu_rdata;
            end
        end
        cpu_req = 1'b0; cpu_we = 1'b0;
        chk("ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic tam(input logic [7:0] sel, input logic [7:0] dat);
        @(negedge clk);
        mpr_we = 1'b1; mpr_sel = sel; mpr_wdata = dat;
        @(negedge clk);
        mpr_we = 1'b0;
    endtask

    logic [7:0]  rd;
    int          lat;
    logic [20:0] aa;
    logic [3:0]  as;
    logic        are, awe;
    int          exp_lat_io;
    logic        ack_any;

    initial begin
`ifdef MMU_IO_WAIT_EN
        exp_lat_io = 3;
`else
        exp_lat_io = 2;
`endif
        // Reset state
        #12;
        chk("rst_rdy",   {31'd0, cpu_rdy}, 32'd1);
        chk("rst_ack",   {31'd0, cpu_ack}, 32'd0);
        chk("rst_rdata", {24'd0, cpu_rdata}, 32'h0);
        chk("rst_strb",  {30'd0, mem_re, mem_we}, 32'd0);
        chk("rst_addr",  {11'd0, mem_addr}, 32'h0);
        chk("rst_dout",  {24'd0, mem_dout}, 32'h0);
        chk("rst_sel",   {28'd0, ce_n, cer_n, ce7_n, cek_n}, 32'hF);
        mpr_rsel = 3'd7; #1;
        chk("rst_mpr7",  {24'd0, mpr_rdata}, 32'h00);
        mpr_rsel = 3'd0; #1;
        chk("rst_mpr0",  {24'd0, mpr_rdata}, 32'hFF);
        @(negedge clk); rst = 1'b0;

        // ROM read through MPR7=00: FFFE -> 001FFE, byte FE^1F^3C = DD
        access(1'b0, 16'hFFFE, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("rom_addr", {11'd0, aa}, 32'h001FFE);
        chk("rom_sel",  {28'd0, as}, 32'b0111);
        chk("rom_re",   {30'd0, are, awe}, 32'b10);
        chk("rom_lat",  lat, 2);
        chk("rom_data", {24'd0, rd}, 32'hDD);

        // TAM MPR1=F8, RAM write then read back
        tam(8'h02, 8'hF8);
        mpr_rsel = 3'd1; #1;
        chk("tma_mpr1", {24'd0, mpr_rdata}, 32'hF8);
        access(1'b1, 16'h2000, 8'h5A, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("ramw_addr", {11'd0, aa}, 32'h1F0000);
        chk("ramw_sel",  {28'd0, as}, 32'b1011);
        chk("ramw_we",   {30'd0, are, awe}, 32'b01);
        chk("ramw_rd",   {24'd0, rd}, 32'hDD);
        access(1'b0, 16'h2000, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("ramr_sel",  {28'd0, as}, 32'b1011);
        chk("ramr_data", {24'd0, rd}, 32'h5A);
        chk("ramr_lat",  lat, 2);

        // MPR0=FF -> VDC at 1FE000, open-bus read, wait state in high-speed builds
        tam(8'h01, 8'hFF);
        speed_hi = 1'b1;
        access(1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        speed_hi = 1'b0;
        chk("vdc_addr", {11'd0, aa}, 32'h1FE000);
        chk("vdc_sel",  {28'd0, as}, 32'b1101);
        chk("vdc_data", {24'd0, rd}, 32'hFF);
        chk("vdc_lat",  lat, exp_lat_io);
        access(1'b0, 16'h0400, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("vce_sel",  {28'd0, as}, 32'b1110);
        chk("vce_lat",  lat, 2);

        // TAM (MPR1<=00) in the same cycle as a request to bank 1: old MPR F8 used
        access(1'b0, 16'h2010, 8'h00, 1'b1, 8'h02, 8'h00, rd, lat, aa, as, are, awe);
        chk("tamreq_addr", {11'd0, aa}, 32'h1F0010);
        chk("tamreq_data", {24'd0, rd}, 32'h2C);
        access(1'b0, 16'h2011, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("tamnext_addr", {11'd0, aa}, 32'h000011);
        chk("tamnext_sel",  {28'd0, as}, 32'b0111);

        // Unmapped region 1F8000: no select, open bus
        tam(8'h04, 8'hFC);
        access(1'b0, 16'h4000, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, aa, as, are, awe);
        chk("none_addr", {11'd0, aa}, 32'h1F8000);
        chk("none_sel",  {28'd0, as}, 32'hF);
        chk("none_data", {24'd0, rd}, 32'hFF);

        // Overlapping TAM mask writes all selected banks
        tam(8'h18, 8'h42);
        mpr_rsel = 3'd3; #1;
        chk("tam_mpr3", {24'd0, mpr_rdata}, 32'h42);
        mpr_rsel = 3'd4; #1;
        chk("tam_mpr4", {24'd0, mpr_rdata}, 32'h42);
        mpr_rsel = 3'd5; #1;
        chk("tam_mpr5", {24'd0, mpr_rdata}, 32'hFF);
        mpr_rsel = 3'd7; #1;
        chk("tma_mpr7", {24'd0, mpr_rdata}, 32'h00);

        // Reset in the middle of an access
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFFFE;
        @(posedge clk); #1;
        chk("abort_in_access", {31'd0, mem_re}, 32'd1);
        #1 rst = 1'b1; #1;
        chk("abort_strb", {30'd0, mem_re, mem_we}, 32'd0);
        chk("abort_sel",  {28'd0, ce_n, cer_n, ce7_n, cek_n}, 32'hF);
        chk("abort_ack",  {31'd0, cpu_ack}, 32'd0);
        mpr_rsel = 3'd1; #1;
        chk("abort_mpr1", {24'd0, mpr_rdata}, 32'hFF);
        cpu_req = 1'b0;
        @(negedge clk); rst = 1'b0;
        ack_any = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            ack_any = ack_any | cpu_ack;
        end
        chk("abort_noack", {31'd0, ack_any}, 32'd0);
        chk("abort_rdy",   {31'd0, cpu_rdy}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
